// File: rtl/uart_frame_parser_pkg.sv
// Shared constants, FSM encoding and the CRC8 (poly 0x07, MSB-first) update
// used by the UART frame parser and its transmit-side counterpart.
package uart_frame_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;
    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam logic [7:0] CRC8_INIT    = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_CRC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HDR  = ST_HDR,
        S_BODY = ST_BODY,
        S_CRC  = ST_CRC
    } state_t;

    // One byte through the shift register: no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and frame-result bundle between the UART receiver side
// (master) and the frame parser (slave).
interface uart_frame_parser_if #(
    parameter int _NUM_BYTES = 11
);
    logic [7:0]              uart_data;
    logic                    uart_done;
    logic [_NUM_BYTES*8-1:0] rev_data;
    logic                    pack_done;
    logic                    crc_err;
    logic                    timeout_err;
    logic [7:0]              frame_cnt;
    logic                    busy;

    modport master (
        output uart_data, uart_done,
        input  rev_data, pack_done, crc_err, timeout_err, frame_cnt, busy
    );

    modport slave (
        input  uart_data, uart_done,
        output rev_data, pack_done, crc_err, timeout_err, frame_cnt, busy
    );
endinterface

// File: rtl/uart_frame_parser_crc8.sv
// Combinational byte-wise CRC8 update; shared with the transmit framer.
module crc8_byte
    import uart_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    assign crc_out = crc8(crc_in, data_in);
endmodule

// File: rtl/uart_frame_parser.sv
// Frame delineation (HDR0 HDR1 body CRC8) with atomic body update on good CRC.
// Optional inter-byte timeout: define FRAME_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | hunting for first header byte
// HDR    | first header seen, expecting second (repeat of first re-syncs)
// BODY   | collecting body bytes into the shadow buffer, running CRC
// CRC    | next byte is compared against the running CRC
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         _NUM_BYTES   = 11,
    parameter logic [7:0] _HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] _HDR1        = HDR1_DEFAULT,
    parameter int         _TIMEOUT_CYC = 50000
) (
    input logic                clk_50M,
    input logic                rst,
    uart_frame_parser_if.slave bus
);

    localparam logic [4:0] IDX_LAST = 5'(_NUM_BYTES - 1);

    state_t                  state, state_nxt;
    logic [4:0]              idx;
    logic [7:0]              crc_q, crc_upd;
    logic [7:0]              shadow [_NUM_BYTES];
    logic [_NUM_BYTES*8-1:0] shadow_flat, rev_data_q;
    logic                    pack_q, crc_err_q, timeout_q, busy_q;
    logic [7:0]              frame_cnt_q;
    logic                    body_start, body_wr, frame_ok, frame_bad, expire;

    crc8_byte u_crc (
        .crc_in  (crc_q),
        .data_in (bus.uart_data),
        .crc_out (crc_upd)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam logic [16:0] TO_LAST = 17'(_TIMEOUT_CYC - 1);
    logic [16:0] to_cnt;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (bus.uart_done || state == S_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 17'd1;
        end
    end

    // A strobe on the expiry cycle takes priority and restarts the timer.
    assign expire = (state != S_IDLE) && !bus.uart_done && (to_cnt == TO_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        body_start = 1'b0;
        body_wr    = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (bus.uart_done) begin
            case (state)
                S_IDLE: begin
                    if (bus.uart_data == _HDR0) state_nxt = S_HDR;
                end
                S_HDR: begin
                    if (bus.uart_data == _HDR1) begin
                        state_nxt  = S_BODY;
                        body_start = 1'b1;
                    end else if (bus.uart_data != _HDR0) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_BODY: begin
                    body_wr = 1'b1;
                    if (idx == IDX_LAST) state_nxt = S_CRC;
                end
                S_CRC: begin
                    frame_ok  = (bus.uart_data == crc_q);
                    frame_bad = (bus.uart_data != crc_q);
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (expire) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < _NUM_BYTES; k++) begin
            shadow_flat[8*k +: 8] = shadow[k];
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            idx         <= '0;
            crc_q       <= CRC8_INIT;
            rev_data_q  <= '0;
            pack_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < _NUM_BYTES; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            pack_q    <= frame_ok;
            crc_err_q <= frame_bad;
            timeout_q <= expire;
            busy_q    <= (state_nxt != S_IDLE);
            if (body_start) begin
                idx   <= '0;
                crc_q <= CRC8_INIT;
            end else if (body_wr) begin
                idx   <= idx + 5'd1;
                crc_q <= crc_upd;
            end
            for (int k = 0; k < _NUM_BYTES; k++) begin
                if (body_wr && idx == 5'(k)) shadow[k] <= bus.uart_data;
            end
            // Body only reaches the register mapper once the whole frame checks out.
            if (frame_ok) begin
                rev_data_q  <= shadow_flat;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign bus.rev_data    = rev_data_q;
    assign bus.pack_done   = pack_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.timeout_err = timeout_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits between the byte-level UART receiver and the register mapper. It consumes byte strobes, delineates frames (header, fixed-length body, CRC8) and validates each frame. Only on a good frame does it atomically update the flattened body-byte bus and pulse pack_done. Malformed, corrupted or stalled frames are dropped and flagged, so the register mapper never sees partial data.

Parameters:
_NUM_BYTES, 11, body bytes per frame (byte 0 = function register); range 1..32
_HDR0, 8'h55, first header byte
_HDR1, 8'hAA, second header byte
_TIMEOUT_CYC, 50000, inter-byte timeout in clk_50M cycles (1 ms); used only with FRAME_TIMEOUT_EN

Ports:
clk_50M  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
uart_data  input  8  received byte
uart_done  input  1  one-cycle strobe; uart_data valid this cycle
rev_data  output  _NUM_BYTES*8  body bytes; byte k at [8k+7:8k]
pack_done  output  1  one-cycle pulse; rev_data updated this cycle
crc_err  output  1  one-cycle pulse; frame dropped on CRC mismatch
timeout_err  output  1  one-cycle pulse; frame aborted on timeout (tied 0 without FRAME_TIMEOUT_EN)
frame_cnt  output  8  good-frame counter, wraps 255->0
busy  output  1  high when state != IDLE

Behaviour:
- One clock (clk_50M). Reset is synchronous, active-high. All outputs are registered.
- Reset values: rev_data=0, pack_done=0, crc_err=0, timeout_err=0, frame_cnt=0, busy=0, state=IDLE, shadow buffer=0, crc=0, byte index=0.
- FSM states: IDLE, HDR, BODY, CRC. All transitions occur only on cycles where uart_done=1.
  - IDLE: byte==_HDR0 -> HDR; otherwise stay in IDLE.
  - HDR: byte==_HDR1 -> BODY, with idx=0 and crc=8'h00. byte==_HDR0 -> stay in HDR (re-sync). Any other byte -> IDLE.
  - BODY: write byte into shadow[idx]; crc=crc8(crc,byte); idx++. After byte _NUM_BYTES-1 -> CRC.
  - CRC: byte==crc -> copy shadow to rev_data, pack_done=1, frame_cnt++. Otherwise crc_err=1 and rev_data is unchanged. Either way -> IDLE.
- CRC8 definition: polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR. Covers body bytes only; the header is excluded.
- Latency: the CRC-byte strobe at cycle T produces pack_done or crc_err at T+1. rev_data is valid starting at T+1 and holds until the next good frame.
- Header bytes in BODY are treated as data; there is no escaping.
- A uart_done pulse on consecutive cycles is legal and processed every cycle.
- Reset asserted mid-frame: state returns to IDLE; rev_data and all other outputs clear on the next edge.
- Pulses are single-cycle; the pulse outputs never assert together.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined: a 17-bit counter clears on every uart_done and increments while state != IDLE.
  - When it reaches _TIMEOUT_CYC-1 with no strobe: -> IDLE, timeout_err=1 for 1 cycle, rev_data unchanged.
  - A strobe in the same cycle as expiry wins: the byte is processed and the timer restarts.
- Undefined: no counter is built, timeout_err is tied 0, and a stalled frame waits indefinitely.

Decomposition:
- Package uart_frame_pkg holds:
  - default header constants 8'h55/8'hAA;
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00;
  - FSM state encoding (2-bit localparams);
  - the crc8 next-state function.
- Sub-module crc8_byte: combinational byte-wise CRC update (crc_in, data_in -> crc_out). It is unit-testable and shared with uart_protocol_tx.

Test Plan:
- 55 AA followed by eleven 00 and CRC 00 -> pack_done at T+1, rev_data=0, frame_cnt=1, crc_err=0.
- 55 AA, body 01 00..00, then wrong CRC 00 -> crc_err=1 at T+1, pack_done=0, rev_data holds its prior value, frame_cnt unchanged.
- 55 55 AA, then a valid zero frame -> accepted (HDR re-sync). 55 12 -> IDLE with no pulses.
- crc8_byte unit check: (00,01)->07; (00,07)->15; (00,00)->00.
- Valid frame, then reset held 1 cycle after byte 5 of a second frame -> all outputs 0. A subsequent valid frame -> frame_cnt=1.
- FRAME_TIMEOUT_EN, _TIMEOUT_CYC=100: stop after byte 3 -> timeout_err exactly 100 cycles after the last strobe and state IDLE. A strobe on the expiry cycle -> no timeout_err.
